// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Data-memory responder for the M stage. Accepts one load or store per
//   request, holds the pipeline with `stall` while the access is in flight,
//   and returns load data tagged with its destination register toward W.
//   The storage is a word-addressed synchronous RAM; the request port carries
//   byte addresses and the word index is req_addr[log2(DEPTH)+1:2]. Upper
//   address bits are ignored, so addresses wrap modulo DEPTH words.
//
//   Timing: a request accepted in cycle T performs its array access on the
//   rising edge that ends cycle T+LATENCY-1. A load response is visible in
//   cycle T+LATENCY. Throughput is one op per LATENCY cycles.
//
// Optional feature (macro MEMRESP_CHECK_EN):
//   defined   - misaligned requests (req_addr[1:0] != 0) keep normal timing
//               but touch no array word; a misaligned load returns 0. `err`
//               pulses in cycle T+LATENCY for misaligned requests and for
//               requests with both read and write high (the latter still
//               performs the store when aligned).
//   undefined - req_addr[1:0] ignored, err tied low.
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   reset_n     in   asynchronous active-low reset
//   req_read    in   load request
//   req_write   in   store request (wins when both are high)
//   req_addr    in   byte address
//   req_val     in   store data
//   req_dst     in   load destination register tag
//   stall       out  hold M and earlier stages; inputs stay stable while high
//   resp_valid  out  one-cycle pulse, load result valid
//   resp_data   out  load data (holds last value between pulses)
//   resp_dst    out  load destination tag (holds last value between pulses)
//   err         out  one-cycle pulse, bad request
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int REG_W   = 5,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_val,
  input  logic [REG_W-1:0]  req_dst,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [REG_W-1:0]  resp_dst,
  output logic              err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam bit         MULTI    = (LATENCY > 1);
  localparam logic [3:0] CNT_INIT = 4'(MULTI ? LATENCY - 2 : 0);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic              wr_q, wr_d;
  logic              mis_q, mis_d;
  logic              both_q, both_d;

  logic              resp_valid_q, resp_valid_d;
  logic [REG_W-1:0]  resp_dst_q, resp_dst_d;
  logic              rd_zero_q, rd_zero_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_raw_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req;
  logic              req_mis;
  logic              req_both;
  logic              do_op;
  logic              op_wr;
  logic              op_mis;
  logic              op_both;
  logic [IDX_W-1:0]  op_idx;
  logic [DATA_W-1:0] op_val;
  logic [REG_W-1:0]  op_dst;
  logic              mem_we;
  logic              mem_re;

  assign req      = req_read | req_write;
  assign req_both = req_read & req_write;

`ifdef MEMRESP_CHECK_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // Upper address bits (and, without the check feature, the byte offset)
  // are intentionally unused.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  // ---------------------------------------------------------------------------
  // Control FSM: next state, request capture and op strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    dst_d   = dst_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    both_d  = both_q;
    do_op   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d  = req_addr[IDX_W+1:2];
          val_d  = req_val;
          dst_d  = req_dst;
          wr_d   = req_write;
          mis_d  = req_mis;
          both_d = req_both;
          if (MULTI) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            do_op = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          do_op   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY=1 the op happens on the accept edge itself, so it consumes
  // the values being captured rather than the (stale) registered copies.
  assign op_wr   = MULTI ? wr_q   : wr_d;
  assign op_mis  = MULTI ? mis_q  : mis_d;
  assign op_both = MULTI ? both_q : both_d;
  assign op_idx  = MULTI ? idx_q  : idx_d;
  assign op_val  = MULTI ? val_q  : val_d;
  assign op_dst  = MULTI ? dst_q  : dst_d;

  // reset_n gating keeps a request held through reset from writing the array
  // (LATENCY=1 path) or raising stall.
  assign mem_we = do_op &  op_wr & ~op_mis & reset_n;
  assign mem_re = do_op & ~op_wr & ~op_mis;

  assign stall = reset_n &
                 (((state_q == IDLE) & req & MULTI) |
                  ((state_q == WAIT) & (cnt_q != 4'd0)));

  // ---------------------------------------------------------------------------
  // Response path.
  // rd_raw_q is the RAM read register (no reset so it can live in block RAM);
  // rd_zero_q forces resp_data to 0 after reset and after a misaligned load.
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_valid_d = do_op & ~op_wr;
    resp_dst_d   = resp_valid_d ? op_dst : resp_dst_q;
    rd_zero_d    = resp_valid_d ? op_mis : rd_zero_q;
`ifdef MEMRESP_CHECK_EN
    err_d        = do_op & (op_mis | op_both);
`else
    err_d        = 1'b0;
`endif
  end

`ifndef MEMRESP_CHECK_EN
  logic unused_both;
  assign unused_both = op_both;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      val_q        <= '0;
      dst_q        <= '0;
      wr_q         <= 1'b0;
      mis_q        <= 1'b0;
      both_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_dst_q   <= '0;
      rd_zero_q    <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      dst_q        <= dst_d;
      wr_q         <= wr_d;
      mis_q        <= mis_d;
      both_q       <= both_d;
      resp_valid_q <= resp_valid_d;
      resp_dst_q   <= resp_dst_d;
      rd_zero_q    <= rd_zero_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[op_idx] <= op_val;
    end
    if (mem_re) begin
      rd_raw_q <= mem[op_idx];
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_dst   = resp_dst_q;
  assign resp_data  = rd_zero_q ? '0 : rd_raw_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Three responders with LATENCY 1, 2 and 4 (instance index 0, 1, 2) are
//   driven one at a time. Expected responses are pushed to a scoreboard when a
//   request is driven and are popped by a negedge monitor in the cycle they
//   are due. Build with +define+MEMRESP_CHECK_EN to also exercise err.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_read   [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_val    [3];
  logic [4:0]  req_dst    [3];
  logic        stall      [3];
  logic        resp_valid [3];
  logic [31:0] resp_data  [3];
  logic [4:0]  resp_dst   [3];
  logic        err        [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      mem_responder #(
        .DATA_W (32),
        .ADDR_W (32),
        .DEPTH  (256),
        .REG_W  (5),
        .LATENCY((gi == 0) ? 1 : (gi == 1) ? 2 : 4)
      ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_read  (req_read[gi]),
        .req_write (req_write[gi]),
        .req_addr  (req_addr[gi]),
        .req_val   (req_val[gi]),
        .req_dst   (req_dst[gi]),
        .stall     (stall[gi]),
        .resp_valid(resp_valid[gi]),
        .resp_data (resp_data[gi]),
        .resp_dst  (resp_dst[gi]),
        .err       (err[gi])
      );
    end
  endgenerate

  typedef struct {
    int          k;
    int          due;
    bit          exp_valid;
    bit          exp_err;
    logic [31:0] data;
    logic [4:0]  dst;
  } rec_t;

  typedef struct {
    int          k;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] val;
    logic [4:0]  dst;
    logic [31:0] exp_data;
  } vec_t;

  rec_t sb [$];
  vec_t tbl [13];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: one line per response/err pulse.
  rec_t r;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sb.size() > 0 && sb[0].k == k && sb[0].due == cyc) begin
        r = sb.pop_front();
        check($sformatf("u%0d resp_valid", k), {31'b0, resp_valid[k]}, {31'b0, r.exp_valid});
        check($sformatf("u%0d err", k), {31'b0, err[k]}, {31'b0, r.exp_err});
        if (r.exp_valid) begin
          check($sformatf("u%0d resp_data", k), resp_data[k], r.data);
          check($sformatf("u%0d resp_dst", k), {27'b0, resp_dst[k]}, {27'b0, r.dst});
        end
        $display("cycle %0d u%0d: valid=%0b err=%0b data=0x%0h dst=%0d", cyc, k,
                 resp_valid[k], err[k], resp_data[k], resp_dst[k]);
      end else if (resp_valid[k] || err[k]) begin
        checks++;
        errors++;
        $display("FAIL u%0d spurious pulse: valid=%0b err=%0b expected none (cycle %0d)",
                 k, resp_valid[k], err[k], cyc);
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL u%0d missing response due cycle %0d: got none expected pulse", sb[0].k, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic clear_inputs(int k);
    req_read[k]  = 1'b0;
    req_write[k] = 1'b0;
    req_addr[k]  = '0;
    req_val[k]   = '0;
    req_dst[k]   = '0;
  endtask

  // Drives one request at posedge+1, holds it for LATENCY cycles while
  // checking stall, then releases it at posedge+1 of cycle T+LATENCY.
  task automatic do_op(int k, bit rd, bit wr, logic [31:0] addr, logic [31:0] val,
                       logic [4:0] dst, logic [31:0] exp_data, bit exp_err);
    int   l = lat_of(k);
    rec_t e;
    req_read[k]  = rd;
    req_write[k] = wr;
    req_addr[k]  = addr;
    req_val[k]   = val;
    req_dst[k]   = dst;
    if ((rd && !wr) || exp_err) begin
      e.k         = k;
      e.due       = cyc + l;
      e.exp_valid = rd && !wr;
      e.exp_err   = exp_err;
      e.data      = exp_data;
      e.dst       = dst;
      sb.push_back(e);
    end
    for (int i = 0; i < l; i++) begin
      @(negedge clk);
      check($sformatf("u%0d stall op-cycle %0d", k, i), {31'b0, stall[k]}, (i < l - 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    clear_inputs(k);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 0, 1, 32'h10,        32'hDEADBEEF, 5'd0,  32'h0};
    tbl[1]  = '{1, 1, 0, 32'h10,        32'h0,        5'd7,  32'hDEADBEEF};
    tbl[2]  = '{1, 0, 1, 32'h400,       32'h55,       5'd0,  32'h0};
    tbl[3]  = '{1, 1, 0, 32'h0,         32'h0,        5'd1,  32'h55};
    tbl[4]  = '{1, 1, 0, 32'hFFFF_FC00, 32'h0,        5'd17, 32'h55};
    tbl[5]  = '{0, 0, 1, 32'h8,         32'h22,       5'd0,  32'h0};
    tbl[6]  = '{0, 0, 1, 32'h4,         32'h11,       5'd0,  32'h0};
    tbl[7]  = '{0, 1, 0, 32'h4,         32'h0,        5'd3,  32'h11};
    tbl[8]  = '{0, 1, 0, 32'h8,         32'h0,        5'd4,  32'h22};
    tbl[9]  = '{2, 0, 1, 32'h20,        32'h77,       5'd0,  32'h0};
    tbl[10] = '{2, 1, 0, 32'h20,        32'h0,        5'd9,  32'h77};
    tbl[11] = '{2, 0, 1, 32'h24,        32'h1234,     5'd0,  32'h0};
    tbl[12] = '{2, 1, 0, 32'h24,        32'h0,        5'd31, 32'h1234};

    // Reset held with a load request present on every instance.
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clear_inputs(k);
      req_read[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d reset stall", k), {31'b0, stall[k]}, 32'd0);
      check($sformatf("u%0d reset resp_valid", k), {31'b0, resp_valid[k]}, 32'd0);
      check($sformatf("u%0d reset resp_data", k), resp_data[k], 32'd0);
      check($sformatf("u%0d reset resp_dst", k), {27'b0, resp_dst[k]}, 32'd0);
      check($sformatf("u%0d reset err", k), {31'b0, err[k]}, 32'd0);
    end
    for (int k = 0; k < 3; k++) clear_inputs(k);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(3);

    // Table: stores/loads, LATENCY=1 back-to-back, address wrap, RAW.
    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].k, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].val,
            tbl[i].dst, tbl[i].exp_data, 1'b0);
    end
    idle(3);

    // Reset mid-op on the LATENCY=4 instance: the store of 0xAA must be lost.
    req_write[2] = 1'b1;
    req_addr[2]  = 32'h20;
    req_val[2]   = 32'hAA;
    @(negedge clk);
    check("u2 stall at accept", {31'b0, stall[2]}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("u2 stall after async reset", {31'b0, stall[2]}, 32'd0);
    clear_inputs(2);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(6);
    do_op(2, 1'b1, 1'b0, 32'h20, 32'h0, 5'd5, 32'h77, 1'b0);
    idle(2);

`ifdef MEMRESP_CHECK_EN
    do_op(1, 1'b1, 1'b0, 32'h13, 32'h0, 5'd2, 32'h0, 1'b1);
    do_op(1, 1'b1, 1'b1, 32'h0,  32'h9, 5'd0, 32'h0, 1'b1);
    do_op(1, 1'b1, 1'b0, 32'h0,  32'h0, 5'd6, 32'h9, 1'b0);
    idle(2);
`endif

    idle(6);
    check("scoreboard drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
